// File: rtl/lsu_load_assembler.sv
// lsu_load_assembler
// Load-side byte-lane assembler for the four byte-wide data-memory banks.
// A load is accepted in IDLE. Bank indices and read enables are driven in ISSUE.
// Bank data is sampled and extended in CAPTURE.
// The result is then held in RESP until the consumer takes it.
//
// Handshake: a request transfers on a rising edge where i_ld_req && o_ld_ready.
// A response transfers on a rising edge where o_ld_valid && i_ld_ready.
// o_ld_data is stable for as long as o_ld_valid is high.
module lsu_load_assembler (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ld_req,
    input  logic [31:0] i_lsu_addr,
    input  logic [2:0]  i_ld,
    output logic        o_ld_ready,
    output logic [9:0]  o_addr_even_1,
    output logic [9:0]  o_addr_even_2,
    output logic [9:0]  o_addr_odd_1,
    output logic [9:0]  o_addr_odd_2,
    output logic        o_re_even_1,
    output logic        o_re_even_2,
    output logic        o_re_odd_1,
    output logic        o_re_odd_2,
    input  logic [7:0]  i_data_even_1,
    input  logic [7:0]  i_data_even_2,
    input  logic [7:0]  i_data_odd_1,
    input  logic [7:0]  i_data_odd_2,
    output logic        o_ld_valid,
    output logic [31:0] o_ld_data,
    input  logic        i_ld_ready
);

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic        r_odd;
    logic [2:0]  r_ld;
    logic [9:0]  r_addr_even_1;
    logic [9:0]  r_addr_even_2;
    logic [9:0]  r_addr_odd_1;
    logic [9:0]  r_addr_odd_2;
    logic        r_re_even_1;
    logic        r_re_even_2;
    logic        r_re_odd_1;
    logic        r_re_odd_2;
    logic [31:0] r_ld_data;

    logic        w_accept;
    logic        w_odd;
    logic [9:0]  w_w0;
    logic [9:0]  w_w1;
    logic [9:0]  w_w2;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_en_b0;
    logic        w_en_b1;
    logic        w_en_hi;
    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_b3;
    logic [31:0] w_ext;
    logic        w_unused_addr;

    // Only the 11-bit byte address space is decoded; upper bits are ignored.
    assign w_unused_addr = ^i_lsu_addr[31:11];

    assign w_accept = i_ld_req && (r_state == S_IDLE);
    assign w_odd    = i_lsu_addr[0];
    assign w_w0     = i_lsu_addr[10:1];
    assign w_w1     = w_w0 + 10'd1;
    assign w_w2     = w_w0 + 10'd2;

    assign w_is_byte = (i_ld == LD_LB) || (i_ld == LD_LBU);
    assign w_is_half = (i_ld == LD_LH) || (i_ld == LD_LHU);
    assign w_is_word = (i_ld == LD_LW);
    // byte0 lane for any supported width, byte1 lane from halfword up, upper lanes for words
    assign w_en_b0   = w_is_byte || w_is_half || w_is_word;
    assign w_en_b1   = w_is_half || w_is_word;
    assign w_en_hi   = w_is_word;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_next_state = r_state;
        o_ld_ready   = 1'b0;
        o_ld_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ld_ready = 1'b1;
                if (i_ld_req) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP: begin
                o_ld_valid = 1'b1;
                if (i_ld_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Latch request; indices hold until the next acceptance, enables last one cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_odd         <= 1'b0;
            r_ld          <= 3'b000;
            r_addr_even_1 <= 10'd0;
            r_addr_even_2 <= 10'd0;
            r_addr_odd_1  <= 10'd0;
            r_addr_odd_2  <= 10'd0;
            r_re_even_1   <= 1'b0;
            r_re_even_2   <= 1'b0;
            r_re_odd_1    <= 1'b0;
            r_re_odd_2    <= 1'b0;
        end else if (w_accept) begin
            r_odd <= w_odd;
            r_ld  <= i_ld;
            if (w_odd) begin
                // byte0 odd_1@W, byte1 even_1@W+1, byte2 odd_2@W+1, byte3 even_2@W+2
                r_addr_odd_1  <= w_w0;
                r_addr_even_1 <= w_w1;
                r_addr_odd_2  <= w_w1;
                r_addr_even_2 <= w_w2;
                r_re_odd_1    <= w_en_b0;
                r_re_even_1   <= w_en_b1;
                r_re_odd_2    <= w_en_hi;
                r_re_even_2   <= w_en_hi;
            end else begin
                // byte0 even_1@W, byte1 odd_1@W, byte2 even_2@W+1, byte3 odd_2@W+1
                r_addr_even_1 <= w_w0;
                r_addr_odd_1  <= w_w0;
                r_addr_even_2 <= w_w1;
                r_addr_odd_2  <= w_w1;
                r_re_even_1   <= w_en_b0;
                r_re_odd_1    <= w_en_b1;
                r_re_even_2   <= w_en_hi;
                r_re_odd_2    <= w_en_hi;
            end
        end else begin
            r_re_even_1 <= 1'b0;
            r_re_even_2 <= 1'b0;
            r_re_odd_1  <= 1'b0;
            r_re_odd_2  <= 1'b0;
        end
    end

    // Route bank outputs back to byte lanes according to the start alignment
    always_comb begin
        w_b0 = r_odd ? i_data_odd_1  : i_data_even_1;
        w_b1 = r_odd ? i_data_even_1 : i_data_odd_1;
        w_b2 = r_odd ? i_data_odd_2  : i_data_even_2;
        w_b3 = r_odd ? i_data_even_2 : i_data_odd_2;
    end

    // Sign/zero extension by load type; unsupported types yield zero
    always_comb begin
        w_ext = 32'h0;
        case (r_ld)
            LD_LB:   w_ext = {{24{w_b0[7]}}, w_b0};
            LD_LBU:  w_ext = {24'h0, w_b0};
            LD_LH:   w_ext = {{16{w_b1[7]}}, w_b1, w_b0};
            LD_LHU:  w_ext = {16'h0, w_b1, w_b0};
            LD_LW:   w_ext = {w_b3, w_b2, w_b1, w_b0};
            default: w_ext = 32'h0;
        endcase
    end

    // Result register: loaded in CAPTURE, held through RESP
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ld_data <= 32'h0;
        end else if (r_state == S_CAPTURE) begin
            r_ld_data <= w_ext;
        end
    end

    assign o_addr_even_1 = r_addr_even_1;
    assign o_addr_even_2 = r_addr_even_2;
    assign o_addr_odd_1  = r_addr_odd_1;
    assign o_addr_odd_2  = r_addr_odd_2;
    assign o_re_even_1   = r_re_even_1;
    assign o_re_even_2   = r_re_even_2;
    assign o_re_odd_1    = r_re_odd_1;
    assign o_re_odd_2    = r_re_odd_2;
    assign o_ld_data     = r_ld_data;

endmodule

// File: tb/tb_lsu_load_assembler.sv
// Directed bench for lsu_load_assembler with a behavioural model of the four
// synchronous-read byte banks. Inputs change and outputs are sampled on the
// falling edge.
module tb_lsu_load_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req;
  logic [31:0] lsu_addr;
  logic [2:0]  ld_type;
  logic        ld_ready_out;
  logic [9:0]  a_e1, a_e2, a_o1, a_o2;
  logic        re_e1, re_e2, re_o1, re_o2;
  logic [7:0]  d_e1, d_e2, d_o1, d_o2;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready_in;

  logic [7:0]  mem_e1 [1024];
  logic [7:0]  mem_e2 [1024];
  logic [7:0]  mem_o1 [1024];
  logic [7:0]  mem_o2 [1024];

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  lsu_load_assembler dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_ld_req      (ld_req),
    .i_lsu_addr    (lsu_addr),
    .i_ld          (ld_type),
    .o_ld_ready    (ld_ready_out),
    .o_addr_even_1 (a_e1),
    .o_addr_even_2 (a_e2),
    .o_addr_odd_1  (a_o1),
    .o_addr_odd_2  (a_o2),
    .o_re_even_1   (re_e1),
    .o_re_even_2   (re_e2),
    .o_re_odd_1    (re_o1),
    .o_re_odd_2    (re_o2),
    .i_data_even_1 (d_e1),
    .i_data_even_2 (d_e2),
    .i_data_odd_1  (d_o1),
    .i_data_odd_2  (d_o2),
    .o_ld_valid    (ld_valid),
    .o_ld_data     (ld_data),
    .i_ld_ready    (ld_ready_in)
  );

  // synchronous-read bank model
  always @(posedge clk) begin
    if (re_e1) d_e1 <= mem_e1[a_e1];
    if (re_e2) d_e2 <= mem_e2[a_e2];
    if (re_o1) d_o1 <= mem_o1[a_o1];
    if (re_o2) d_o2 <= mem_o2[a_o2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // enables packed as {even_1, even_2, odd_1, odd_2}
  task automatic check_banks(input string tag, input logic [3:0] exp_re, input bit chk_addr,
                             input logic [9:0] e1, input logic [9:0] e2,
                             input logic [9:0] o1, input logic [9:0] o2);
    check({tag, "/re"}, {28'd0, re_e1, re_e2, re_o1, re_o2}, {28'd0, exp_re});
    if (chk_addr) begin
      check({tag, "/addr_e1"}, {22'd0, a_e1}, {22'd0, e1});
      check({tag, "/addr_e2"}, {22'd0, a_e2}, {22'd0, e2});
      check({tag, "/addr_o1"}, {22'd0, a_o1}, {22'd0, o1});
      check({tag, "/addr_o2"}, {22'd0, a_o2}, {22'd0, o2});
    end
  endtask

  // driver: present a request at a falling edge; it is accepted at the next
  // rising edge (cycle N). Returns at the falling edge inside cycle N+1.
  task automatic request(input logic [31:0] addr, input logic [2:0] ld);
    check("req/ready_before", {31'd0, ld_ready_out}, 32'd1);
    ld_req   = 1'b1;
    lsu_addr = addr;
    ld_type  = ld;
    @(negedge clk);
    ld_req   = 1'b0;
    lsu_addr = $urandom;
    ld_type  = 3'($urandom_range(0, 7));
  endtask

  // full load with i_ld_ready held high: checks N+1 .. N+4
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] ld,
                          input logic [3:0] exp_re, input bit chk_addr,
                          input logic [9:0] e1, input logic [9:0] e2,
                          input logic [9:0] o1, input logic [9:0] o2,
                          input logic [31:0] exp_data);
    request(addr, ld);
    check_banks({tag, "/issue"}, exp_re, chk_addr, e1, e2, o1, o2);
    check({tag, "/issue_valid"}, {31'd0, ld_valid}, 32'd0);
    @(negedge clk);
    check({tag, "/capture_valid"}, {31'd0, ld_valid}, 32'd0);
    check({tag, "/capture_re"}, {28'd0, re_e1, re_e2, re_o1, re_o2}, 32'd0);
    @(negedge clk);
    check({tag, "/resp_valid"}, {31'd0, ld_valid}, 32'd1);
    check({tag, "/resp_data"}, ld_data, exp_data);
    check({tag, "/resp_ready"}, {31'd0, ld_ready_out}, 32'd0);
    @(negedge clk);
    check({tag, "/idle_ready"}, {31'd0, ld_ready_out}, 32'd1);
    check({tag, "/idle_valid"}, {31'd0, ld_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/ready"}, {31'd0, ld_ready_out}, 32'd1);
    check({tag, "/valid"}, {31'd0, ld_valid}, 32'd0);
    check({tag, "/data"}, ld_data, 32'd0);
    check_banks(tag, 4'b0000, 1'b1, 10'd0, 10'd0, 10'd0, 10'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_e1[i] = 8'h00;
      mem_e2[i] = 8'h00;
      mem_o1[i] = 8'h00;
      mem_o2[i] = 8'h00;
    end
    d_e1 = 8'h00; d_e2 = 8'h00; d_o1 = 8'h00; d_o2 = 8'h00;
    reset       = 1'b1;
    ld_req      = 1'b0;
    lsu_addr    = 32'h0;
    ld_type     = 3'b000;
    ld_ready_in = 1'b1;

    // reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // LW, even address; upper address bits must be ignored
    mem_e1[5] = 8'h11; mem_o1[5] = 8'h22; mem_e2[6] = 8'h33; mem_o2[6] = 8'h44;
    run_load("lw_even", 32'hFFFF_F00A, 3'b010, 4'b1111, 1'b1,
             10'd5, 10'd6, 10'd5, 10'd6, 32'h4433_2211);
    check("lw_even/addr_held", {22'd0, a_e2}, 32'd6);

    // odd-address extension: byte0 = odd_1@5 = 80, byte1 = even_1@6 = FF
    mem_o1[5] = 8'h80; mem_e1[6] = 8'hFF; mem_o2[6] = 8'h44; mem_e2[7] = 8'h5A;
    run_load("lh_odd", 32'h0000_000B, 3'b001, 4'b1010, 1'b1,
             10'd6, 10'd7, 10'd5, 10'd6, 32'hFFFF_FF80);
    run_load("lhu_odd", 32'h0000_000B, 3'b101, 4'b1010, 1'b1,
             10'd6, 10'd7, 10'd5, 10'd6, 32'h0000_FF80);
    run_load("lb_odd", 32'h0000_000B, 3'b000, 4'b0010, 1'b1,
             10'd6, 10'd7, 10'd5, 10'd6, 32'hFFFF_FF80);
    run_load("lbu_odd", 32'h0000_000B, 3'b100, 4'b0010, 1'b1,
             10'd6, 10'd7, 10'd5, 10'd6, 32'h0000_0080);
    run_load("lw_odd", 32'h0000_000B, 3'b010, 4'b1111, 1'b1,
             10'd6, 10'd7, 10'd5, 10'd6, 32'h5A44_FF80);
    // even byte load: byte0 = even_1@5 = 11
    run_load("lbu_even", 32'h0000_000A, 3'b100, 4'b1000, 1'b1,
             10'd5, 10'd6, 10'd5, 10'd6, 32'h0000_0011);

    // wrap-around at the top of the index space
    mem_o1[1023] = 8'hA1; mem_e1[0] = 8'hB2; mem_o2[0] = 8'hC3; mem_e2[1] = 8'hD4;
    run_load("lw_wrap", 32'h0000_07FF, 3'b010, 4'b1111, 1'b1,
             10'd0, 10'd1, 10'd1023, 10'd0, 32'hD4C3_B2A1);

    // unsupported type: no enables, zero result, handshake completes
    run_load("ld_011", 32'h0000_000A, 3'b011, 4'b0000, 1'b0,
             10'd0, 10'd0, 10'd0, 10'd0, 32'h0000_0000);

    // response backpressure: LH even -> {odd_1@5, even_1@5} = 80 11
    ld_ready_in = 1'b0;
    request(32'h0000_000A, 3'b001);
    check_banks("bp/issue", 4'b1010, 1'b1, 10'd5, 10'd6, 10'd5, 10'd6);
    @(negedge clk);
    @(negedge clk);
    check("bp/valid0", {31'd0, ld_valid}, 32'd1);
    check("bp/data0", ld_data, 32'hFFFF_8011);
    for (int k = 0; k < 5; k++) begin
      ld_req   = k[0];
      lsu_addr = 32'h0000_07FF;
      ld_type  = 3'b010;
      @(negedge clk);
      check("bp/hold_valid", {31'd0, ld_valid}, 32'd1);
      check("bp/hold_data", ld_data, 32'hFFFF_8011);
      check("bp/hold_ready", {31'd0, ld_ready_out}, 32'd0);
      check_banks("bp/hold", 4'b0000, 1'b1, 10'd5, 10'd6, 10'd5, 10'd6);
    end
    ld_req      = 1'b0;
    ld_ready_in = 1'b1;
    @(negedge clk);
    check("bp/done_valid", {31'd0, ld_valid}, 32'd0);
    check("bp/done_ready", {31'd0, ld_ready_out}, 32'd1);
    check_banks("bp/done", 4'b0000, 1'b1, 10'd5, 10'd6, 10'd5, 10'd6);
    @(negedge clk);
    check("bp/no_issue", {28'd0, re_e1, re_e2, re_o1, re_o2}, 32'd0);

    // reset asserted during CAPTURE discards the load
    request(32'h0000_000A, 3'b010);
    check_banks("rst/issue", 4'b1111, 1'b1, 10'd5, 10'd6, 10'd5, 10'd6);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst/after");
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst/no_valid", {31'd0, ld_valid}, 32'd0);
      check("rst/ready", {31'd0, ld_ready_out}, 32'd1);
    end

    // block still works after the discarded load
    run_load("lw_post_reset", 32'h0000_000A, 3'b010, 4'b1111, 1'b1,
             10'd5, 10'd6, 10'd5, 10'd6, 32'h4433_8011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_load_assembler.md
# lsu_load_assembler

Load-side counterpart of the store byte-lane decoder in the LSU. It accepts a load request (address plus load type), drives read addresses and read enables to the four byte-wide data-memory banks (even_1, even_2, odd_1, odd_2), captures the synchronous-read bank outputs, and reassembles them into a 32-bit value. The value is sign- or zero-extended and returned to the core over a valid/ready handshake. Bank indexing is identical to the store path, so any byte written by a store is read back from the same bank and index.

## Interface
- No parameters. Bank index width is fixed at 10 bits; byte address space is 11 bits.
- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_ld_req  in  1  load request, qualified by o_ld_ready
- i_lsu_addr  in  32  byte address; only bits [10:0] are used
- i_ld  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are unsupported
- o_ld_ready  out  1  block is idle and can accept a request
- o_addr_even_1, o_addr_even_2, o_addr_odd_1, o_addr_odd_2  out  10 each  bank read indices
- o_re_even_1, o_re_even_2, o_re_odd_1, o_re_odd_2  out  1 each  bank read enables
- i_data_even_1, i_data_even_2, i_data_odd_1, i_data_odd_2  in  8 each  bank read data, valid one cycle after the enable
- o_ld_valid  out  1  load result is valid
- o_ld_data  out  32  extended load result
- i_ld_ready  in  1  consumer accepts the result

## Operation
- **Request capture.** A request is accepted when i_ld_req and o_ld_ready are both high. The block then registers A = i_lsu_addr[10:0] and the load type. No other input is sampled until the next acceptance.
- **Index mapping.** Let W = A[10:1]. All sums are taken modulo 1024 (10-bit wrap).
  - A even: byte0 from even_1@W, byte1 from odd_1@W, byte2 from even_2@W+1, byte3 from odd_2@W+1.
  - A odd: byte0 from odd_1@W, byte1 from even_1@W+1, byte2 from odd_2@W+1, byte3 from even_2@W+2.
- **Read enables.** Only the banks needed for the access width are enabled:
  - byte loads: the byte0 bank only.
  - halfword loads: the byte0 and byte1 banks.
  - word loads: all four banks.
  - unsupported types: no bank.
- **Misaligned access.** Halfword and word loads at any alignment are legal and need no extra cycles.
- **Extension rules.**
  - LB: sign-extend byte0 from bit 7.
  - LBU: zero-extend byte0.
  - LH: sign-extend {byte1, byte0} from bit 15.
  - LHU: zero-extend {byte1, byte0}.
  - LW: {byte3, byte2, byte1, byte0}.
  - Unsupported types: result is 32'h0, the full handshake still completes, and no bank is enabled.
- **State machine.**
  - IDLE: o_ld_ready = 1. Accepting a request moves to ISSUE.
  - ISSUE: the registered bank indices and enables are driven for exactly this cycle. Always moves to CAPTURE.
  - CAPTURE: bank data is sampled, assembled and extended into o_ld_data. Always moves to RESP.
  - RESP: o_ld_valid = 1 and o_ld_data is held stable. If i_ld_ready = 1, moves to IDLE; otherwise stays in RESP.

## Timing
- **Reset values.** Every output is 0 except o_ld_ready: all o_addr_*, all o_re_*, o_ld_valid and o_ld_data are 0, and o_ld_ready is 1 (state IDLE).
- **Reset during a load.** Asserting i_reset in any state returns the block to IDLE on the next edge. The outstanding load is discarded, and no o_ld_valid pulse appears for it.
- **Latency.** With the request accepted in cycle N:
  - enables are high in N+1;
  - bank data is valid in N+2 and registered at the end of N+2;
  - o_ld_valid first goes high in N+3.
- **Enables and indices.** o_re_* are high only in ISSUE and 0 in every other state. o_addr_* hold their last value outside ISSUE.
- **Response handshake.** o_ld_valid stays high and o_ld_data stays stable until the cycle in which i_ld_ready = 1; the transfer completes in that cycle. o_ld_ready rises in the following cycle, so peak throughput is one load per 4 cycles.
- **Requests while busy.** i_ld_req is ignored whenever o_ld_ready = 0. The block does not queue requests.
- **Early i_ld_ready.** i_ld_ready high before RESP has no effect.

## Test plan
- **LW, even address.** Preload even_1@5=0x11, odd_1@5=0x22, even_2@6=0x33, odd_2@6=0x44; LW at A=0x00A with i_ld_ready held 1 -> enables all high in N+1 with indices 5, 5, 6, 6; o_ld_valid in N+3 with o_ld_data=0x44332211; o_ld_ready back high in N+4.
- **Odd-address extension.** Preload odd_1@5=0x80, even_1@6=0xFF; request at A=0x00B.
  - LH -> 0xFFFFFF80 (wait — see correction below).
  - Correction: {byte1, byte0} = 0xFF80, so LH -> 0xFFFFFF80 and LHU -> 0x0000FF80.
  - LB at A=0x00B -> 0xFFFFFF80, with only o_re_odd_1 high.
- **Wrap-around.** LW at A=0x7FF -> indices odd_1=1023, even_1=0, odd_2=0, even_2=1.
- **Response backpressure.** Hold i_ld_ready=0 for 5 cycles in RESP -> o_ld_valid and o_ld_data stay stable; i_ld_req pulses during that time are ignored; the transfer completes on the first i_ld_ready=1.
- **Reset mid-load.** Assert i_reset in CAPTURE -> the next cycle shows IDLE, all outputs at reset values, and no o_ld_valid pulse.
- **Unsupported type.** i_ld=011 -> no o_re_* asserted; o_ld_valid in N+3 with o_ld_data=0.
